i2c_master_param: RTL and testbench

I2C_MASTER_PARAM -- requirements
Module: i2c_master_param

---
 rtl/i2c_master_param_if.sv | 27 ++
 rtl/i2c_master_param.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_param.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_param_if.sv
// Request/response side of the I2C write master: a start pulse with payload in,
// busy/done/ack status and a state debug view out.
`timescale 1ns/1ps

interface i2c_master_param_if #(
    parameter int NUM_BYTES = 3
);
    // start is sampled only while idle; busy covers the bus activity, done pulses
    // once at the end with ack/nack_idx valid and held until the next accepted start.
    logic                   start;
    logic [8*NUM_BYTES-1:0] i2c_data;
    logic                   busy;
    logic                   done;
    logic                   ack;
    logic [2:0]             nack_idx;
    logic [2:0]             state_dbg;

    modport master (
        input  start, i2c_data,
        output busy, done, ack, nack_idx, state_dbg
    );

    modport slave (
        output start, i2c_data,
        input  busy, done, ack, nack_idx, state_dbg
    );
endinterface

// File: rtl/i2c_master_param.sv
// Single-master I2C write engine: START, NUM_BYTES bytes each followed by an ACK
// slot, STOP. Every bus bit is four quarter-periods of QDIV clk cycles.
`timescale 1ns/1ps

module i2c_master_param #(
    parameter int NUM_BYTES     = 3,
    parameter int QDIV          = 32,
    parameter int ABORT_ON_NACK = 1
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_param_if.master bus,
    output logic               i2c_sclk,
    inout  wire                i2c_sdat
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int QW = $clog2(QDIV);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_ACKBIT = 3'd3,
        S_STOP   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [2:0]    nack_idx_r;
    logic [W-1:0]  shreg;
    logic          ack_fail;
    logic          nack_cur;
    logic          ack_r;
    logic          sda_low;
    logic          busy_c;
    logic          done_c;
    logic          q_end;
    logic          phase_end;
    logic          last_byte;
    logic          ack_sample;

    assign q_end      = (qcnt == QW'(QDIV - 1));
    assign phase_end  = q_end && (phase == 2'd3);
    assign last_byte  = (byte_cnt == 3'(NUM_BYTES - 1));
    assign ack_sample = (state == S_ACKBIT) && (phase == 2'd1) && q_end;

    always_comb begin
        state_next = state;
        i2c_sclk   = 1'b1;
        sda_low    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_START;
            end
            S_START: begin
                busy_c   = 1'b1;
                i2c_sclk = (phase < 2'd2);
                sda_low  = (phase != 2'd0);
                if (phase_end) state_next = S_DATA;
            end
            S_DATA: begin
                busy_c   = 1'b1;
                i2c_sclk = (phase == 2'd1) || (phase == 2'd2);
                sda_low  = !shreg[W-1];
                if (phase_end && (bit_cnt == 3'd0)) state_next = S_ACKBIT;
            end
            S_ACKBIT: begin
                busy_c   = 1'b1;
                i2c_sclk = (phase == 2'd1) || (phase == 2'd2);
                if (phase_end) begin
                    if (((ABORT_ON_NACK != 0) && nack_cur) || last_byte) state_next = S_STOP;
                    else                                                 state_next = S_DATA;
                end
            end
            S_STOP: begin
                busy_c   = 1'b1;
                i2c_sclk = (phase != 2'd0);
                sda_low  = (phase != 2'd3);
                if (phase_end) state_next = S_FIN;
            end
            S_FIN: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            phase      <= 2'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            nack_idx_r <= 3'd0;
            shreg      <= '0;
            ack_fail   <= 1'b0;
            nack_cur   <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            state <= state_next;
            // Quarter/phase counters only run while the bus is being driven.
            if ((state == S_IDLE) || (state == S_FIN)) begin
                qcnt  <= '0;
                phase <= 2'd0;
            end else if (q_end) begin
                qcnt  <= '0;
                phase <= (phase == 2'd3) ? 2'd0 : phase + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg      <= bus.i2c_data;
                        ack_r      <= 1'b0;
                        nack_idx_r <= 3'd0;
                        ack_fail   <= 1'b0;
                        bit_cnt    <= 3'd7;
                        byte_cnt   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (phase_end) begin
                        shreg   <= {shreg[W-2:0], 1'b0};
                        bit_cnt <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
                    end
                end
                S_ACKBIT: begin
                    if (ack_sample) begin
                        nack_cur <= i2c_sdat;
                        // Only the first NACKed byte is reported.
                        if (i2c_sdat && !ack_fail) begin
                            ack_fail   <= 1'b1;
                            nack_idx_r <= byte_cnt;
                        end
                    end
                    if (phase_end && (state_next == S_DATA)) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        bit_cnt  <= 3'd7;
                    end
                end
                S_STOP: begin
                    if (phase_end) ack_r <= !ack_fail;
                end
                default: ;
            endcase
        end
    end

    // Open drain: only ever pull low, the pull-up supplies the high level.
    assign i2c_sdat      = sda_low ? 1'b0 : 1'bz;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.ack       = ack_r;
    assign bus.nack_idx  = nack_idx_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_i2c_master_param.sv
// Bench for i2c_master_param: an aborting and a non-aborting instance run the same
// directed transactions against an ACK/NACK slave; a quarter-level bus model predicts every cycle.
`timescale 1ns/1ps

module tb_i2c_master_param;
    localparam int NB = 3;
    localparam int QD = 4;
    localparam int W  = 8 * NB;
    localparam logic [4:0] IDLE_E = 5'b00111;  // {busy, done, sclk, sda_care, sda}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] data  = '0;

    i2c_master_param_if #(.NUM_BYTES(NB)) bus_a ();
    i2c_master_param_if #(.NUM_BYTES(NB)) bus_f ();
    assign bus_a.start    = start;
    assign bus_a.i2c_data = data;
    assign bus_f.start    = start;
    assign bus_f.i2c_data = data;

    wire  sda_a, sda_f;
    logic sclk_a, sclk_f;
    logic [1:0] slave_low = 2'b00;
    pullup pu_a (sda_a);
    pullup pu_f (sda_f);
    assign sda_a = slave_low[0] ? 1'b0 : 1'bz;
    assign sda_f = slave_low[1] ? 1'b0 : 1'bz;

    i2c_master_param #(.NUM_BYTES(NB), .QDIV(QD), .ABORT_ON_NACK(1)) u_abort (
        .clk(clk), .rst(rst), .bus(bus_a), .i2c_sclk(sclk_a), .i2c_sdat(sda_a));
    i2c_master_param #(.NUM_BYTES(NB), .QDIV(QD), .ABORT_ON_NACK(0)) u_full (
        .clk(clk), .rst(rst), .bus(bus_f), .i2c_sclk(sclk_f), .i2c_sdat(sda_f));

    wire [1:0] sclk_v = {sclk_f, sclk_a};
    wire [1:0] sda_v  = {sda_f, sda_a};
    wire [1:0] busy_v = {bus_f.busy, bus_a.busy};
    wire [1:0] done_v = {bus_f.done, bus_a.done};
    wire [1:0] ack_v  = {bus_f.ack, bus_a.ack};
    wire [5:0] idx_v  = {bus_f.nack_idx, bus_a.nack_idx};

    // ---------------- slave: ACK/NACK per byte from nmask_cur ----------------
    logic [7:0] nmask_cur = 8'h00;
    int         rise_cnt[2];
    int         rise_base[2];
    logic [1:0] sclk_p = 2'b11;

    initial begin
        rise_cnt[0] = 0;  rise_cnt[1] = 0;
        rise_base[0] = 0; rise_base[1] = 0;
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int n;
            if (sclk_v[g] && !sclk_p[g]) rise_cnt[g] <= rise_cnt[g] + 1;
            if (!sclk_v[g] && sclk_p[g]) begin
                n = rise_cnt[g] - rise_base[g];
                if (n > 0 && (n % 9) == 8) slave_low[g] <= !nmask_cur[(n / 9) % 8];
                else                       slave_low[g] <= 1'b0;
            end
        end
        sclk_p <= sclk_v;
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    logic [4:0] seq_tmp[$];
    bit         exp_ack[2];
    logic [2:0] exp_idx[2];
    int         exp_len[2];
    int         done_tot[2];
    int         viol[2];
    int         cyc       = 0;
    int         start_cyc = 0;

    initial begin
        exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
        exp_idx[0] = 3'd0; exp_idx[1] = 3'd0;
        exp_len[0] = 0;    exp_len[1] = 0;
        done_tot[0] = 0;   done_tot[1] = 0;
        viol[0] = 0;       viol[1] = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_q(input logic b, input logic s, input logic c, input logic d);
        repeat (QD) seq_tmp.push_back({b, 1'b0, s, c, d});
    endtask

    // Quarter-level picture of one transaction as seen on the wires.
    task automatic build(input logic [W-1:0] d, input logic [7:0] nm, input bit abort,
                         output bit e_ack, output logic [2:0] e_idx, output int e_len);
        seq_tmp.delete();
        e_ack = 1'b1;
        e_idx = 3'd0;
        push_q(1'b1, 1'b1, 1'b1, 1'b1); push_q(1'b1, 1'b1, 1'b1, 1'b0);
        push_q(1'b1, 1'b0, 1'b1, 1'b0); push_q(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NB; i++) begin
            for (int b = 7; b >= 0; b--) begin
                logic v;
                v = d[W - 8 - 8 * i + b];
                push_q(1'b1, 1'b0, 1'b0, 1'b0); push_q(1'b1, 1'b1, 1'b1, v);
                push_q(1'b1, 1'b1, 1'b1, v);    push_q(1'b1, 1'b0, 1'b0, 1'b0);
            end
            push_q(1'b1, 1'b0, 1'b0, 1'b0); push_q(1'b1, 1'b1, 1'b0, 1'b0);
            push_q(1'b1, 1'b1, 1'b0, 1'b0); push_q(1'b1, 1'b0, 1'b0, 1'b0);
            if (nm[i]) begin
                if (e_ack) e_idx = 3'(i);
                e_ack = 1'b0;
                if (abort) break;
            end
        end
        push_q(1'b1, 1'b0, 1'b1, 1'b0); push_q(1'b1, 1'b1, 1'b1, 1'b0);
        push_q(1'b1, 1'b1, 1'b1, 1'b0); push_q(1'b1, 1'b1, 1'b1, 1'b1);
        seq_tmp.push_back(5'b01111);
        e_len = seq_tmp.size();
    endtask

    // Compare process: one model entry per clk cycle, idle picture when nothing queued.
    logic [1:0] prev_sclk = 2'b11;
    logic [1:0] prev_sda  = 2'b11;
    logic [9:0] prev_e    = {IDLE_E, IDLE_E};

    always @(posedge clk) begin
        logic [9:0] e;
        logic [4:0] eg, pe;
        #1;
        cyc = cyc + 1;
        if (rst) begin
            prev_e = {IDLE_E, IDLE_E};
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {IDLE_E, IDLE_E};
            for (int g = 0; g < 2; g++) begin
                eg = e[g*5 +: 5];
                pe = prev_e[g*5 +: 5];
                check(g == 0 ? "wave_abort" : "wave_full",
                      {busy_v[g], done_v[g], sclk_v[g], eg[1] ? sda_v[g] : 1'b0},
                      {eg[4:2], eg[1] & eg[0]});
                if (prev_sclk[g] && sclk_v[g] && (sda_v[g] !== prev_sda[g]))
                    if (!(pe[1] && eg[1] && (pe[0] != eg[0]))) viol[g]++;
                if (done_v[g]) begin
                    done_tot[g]++;
                    check(g == 0 ? "ack_abort" : "ack_full", ack_v[g], exp_ack[g]);
                    check(g == 0 ? "nack_idx_abort" : "nack_idx_full", idx_v[g*3 +: 3], exp_idx[g]);
                    check(g == 0 ? "length_abort" : "length_full", cyc - start_cyc + 1, exp_len[g]);
                end
            end
            prev_e = e;
        end
        prev_sclk = sclk_v;
        prev_sda  = sda_v;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
        check("model_drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sclk"}, sclk_v, 2'b11);
        check({tag, "_sda"}, sda_v, 2'b11);
        check({tag, "_busy"}, busy_v, 2'b00);
        check({tag, "_done"}, done_v, 2'b00);
        check({tag, "_ack"}, ack_v, 2'b00);
        check({tag, "_nack_idx"}, idx_v, 6'd0);
    endtask

    // pulse: hammer start/data while busy and once in the FIN cycle.
    // cut > 0: assert rst that many cycles after the accepted start.
    task automatic run_txn(input logic [W-1:0] d, input logic [7:0] nm, input bit pulse, input int cut);
        logic [4:0] sa[$];
        logic [4:0] sf[$];
        int         t0[2];
        int         n;
        wait_drain();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("ack_hold", ack_v[g], exp_ack[g]);
            check("nack_idx_hold", idx_v[g*3 +: 3], exp_idx[g]);
        end
        build(d, nm, 1'b1, exp_ack[0], exp_idx[0], exp_len[0]);
        sa = seq_tmp;
        build(d, nm, 1'b0, exp_ack[1], exp_idx[1], exp_len[1]);
        sf = seq_tmp;
        n = (sa.size() > sf.size()) ? sa.size() : sf.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i < sf.size()) ? sf[i] : IDLE_E, (i < sa.size()) ? sa[i] : IDLE_E});
        t0[0] = done_tot[0];
        t0[1] = done_tot[1];
        nmask_cur    = nm;
        rise_base[0] = rise_cnt[0];
        rise_base[1] = rise_cnt[1];
        start_cyc    = cyc + 1;
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (cut > 0) begin
            repeat (cut - 1) @(negedge clk);
            rst = 1'b1;
            exp_q.delete();
            #1;
            check_reset_outputs("midreset");
            exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
            exp_idx[0] = 3'd0; exp_idx[1] = 3'd0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        for (int i = 0; i < 2000; i++) begin
            if (done_tot[0] != t0[0] && done_tot[1] != t0[1]) break;
            if (pulse) begin
                start = 1'($urandom_range(0, 1));
                data  = ~data;
            end
            @(negedge clk);
        end
        if (pulse) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain();
        @(negedge clk);
        check("done_count_abort", done_tot[0] - t0[0], 1);
        check("done_count_full", done_tot[1] - t0[1], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // All bytes ACKed, reference payload.
        run_txn(24'h34_1E_00, 8'h00, 1'b0, 0);
        check("model_len_all_ack", exp_len[1], 465);

        // Byte 1 NACKed: abort instance stops early, full instance sends everything.
        run_txn(24'h34_1E_00, 8'h02, 1'b0, 0);
        check("model_len_abort_b1", exp_len[0], 321);
        check("model_idx_abort_b1", exp_idx[0], 1);
        check("model_ack_full_b1", exp_ack[1], 0);

        // Bytes 0 and 2 NACKed: only the first is reported.
        run_txn(24'hA5_FF_01, 8'h05, 1'b0, 0);
        check("model_len_abort_b0", exp_len[0], 177);
        check("model_idx_full_b02", exp_idx[1], 0);

        // Only the last byte NACKed: both instances run the full length.
        run_txn(24'h00_00_FF, 8'h04, 1'b0, 0);
        check("model_idx_last", exp_idx[0], 2);

        // start/data hammered while busy and in the done cycle.
        run_txn(24'hC3_3C_81, 8'h00, 1'b1, 0);

        // Reset in the middle of byte 1, then a clean transaction.
        run_txn(24'hFF_55_AA, 8'h00, 1'b0, 200);
        run_txn(24'h5A_C3_7E, 8'h00, 1'b0, 0);
        check("model_ack_after_reset", exp_ack[1], 1);

        repeat (4) @(negedge clk);
        check("protocol_abort", viol[0], 0);
        check("protocol_full", viol[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
